// File: rtl/byte_unstriping_pkg.sv
// Shared constants and state encodings for the byte unstriping stage.
package byte_unstriping_pkg;

    localparam int DEF_DATA_W = 8;
    localparam int VALID_BIT  = DEF_DATA_W;
    localparam int LANE_W     = DEF_DATA_W + 1;

    // Which lane FIFO the merge logic reads from next.
    typedef enum logic {
        LANE0 = 1'b0,
        LANE1 = 1'b1
    } sel_e;

endpackage

// File: rtl/byte_unstriping_lane_fifo.sv
// Small synchronous show-ahead FIFO buffering one lane of the unstriper.
// Pointers carry an extra wrap bit so full and empty are distinguishable.
module lane_fifo
    import byte_unstriping_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic             clk2f,
    input  logic             reset_L,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout,
    output logic             full,
    output logic             empty
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] PTR_ONE = {{AW{1'b0}}, 1'b1};

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW:0]      wr_ptr;
    logic [AW:0]      rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign empty   = (wr_ptr == rd_ptr);
    assign full    = (wr_ptr[AW] != rd_ptr[AW]) &&
                     (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign do_pop  = pop && !empty;
    // A full FIFO still takes a write when the head leaves in the same cycle.
    assign do_push = push && (!full || do_pop);
    assign dout    = mem[rd_ptr[AW-1:0]];

    // Advance read/write pointers; reset discards all buffered entries.
    always_ff @(posedge clk2f) begin
        if (!reset_L) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + PTR_ONE;
            if (do_pop)  rd_ptr <= rd_ptr + PTR_ONE;
        end
    end

    // Storage array; contents are don't-care until written.
    always_ff @(posedge clk2f) begin
        if (do_push) mem[wr_ptr[AW-1:0]] <= din;
    end

endmodule

// File: rtl/byte_unstriping.sv
// Re-merges the two striped lanes into a single byte stream at clk2f rate,
// lane0 byte first, then lane1 byte. Each lane is buffered in a lane_fifo.
module byte_unstriping
    import byte_unstriping_pkg::*;
#(
    parameter int DATA_W = DEF_DATA_W,
    parameter int DEPTH  = 4
) (
    input  logic              clk2f,
    input  logic              reset_L,
    input  logic              lane_strobe,
    input  logic [DATA_W:0]   lane0,
    input  logic [DATA_W:0]   lane1,
    output logic [DATA_W:0]   dataout0,
    output logic              overflow_err,
    output logic              order_err
);

    logic              lane0_valid;
    logic              lane1_valid;
    logic              push0;
    logic              push1;
    logic              pop0;
    logic              pop1;
    logic              full0;
    logic              full1;
    logic              empty0;
    logic              empty1;
    logic [DATA_W:0]   din0;
    logic [DATA_W:0]   dout0;
    logic [DATA_W-1:0] dout1;
    logic              order_event;
    logic              overflow_event;
    logic [DATA_W:0]   next_out;
    sel_e              sel;
    sel_e              next_sel;

    assign lane0_valid = lane0[DATA_W];
    assign lane1_valid = lane1[DATA_W];

    // fifo0 entries carry the pair bit so the reader knows a lane1 byte follows.
    assign push0 = lane_strobe && lane0_valid;
    assign push1 = lane_strobe && lane0_valid && lane1_valid;
    assign din0  = {lane1_valid, lane0[DATA_W-1:0]};

    assign order_event    = lane_strobe && !lane0_valid && lane1_valid;
    assign overflow_event = (push0 && full0 && !pop0) ||
                            (push1 && full1 && !pop1);

    lane_fifo #(
        .WIDTH (DATA_W + 1),
        .DEPTH (DEPTH)
    ) fifo0 (
        .clk2f   (clk2f),
        .reset_L (reset_L),
        .push    (push0),
        .pop     (pop0),
        .din     (din0),
        .dout    (dout0),
        .full    (full0),
        .empty   (empty0)
    );

    lane_fifo #(
        .WIDTH (DATA_W),
        .DEPTH (DEPTH)
    ) fifo1 (
        .clk2f   (clk2f),
        .reset_L (reset_L),
        .push    (push1),
        .pop     (pop1),
        .din     (lane1[DATA_W-1:0]),
        .dout    (dout1),
        .full    (full1),
        .empty   (empty1)
    );

    // Merge decision: read only the lane whose turn it is, otherwise idle.
    always_comb begin
        pop0     = 1'b0;
        pop1     = 1'b0;
        next_sel = sel;
        next_out = '0;
        case (sel)
            LANE0: begin
                if (!empty0) begin
                    pop0     = 1'b1;
                    next_out = {1'b1, dout0[DATA_W-1:0]};
                    next_sel = dout0[DATA_W] ? LANE1 : LANE0;
                end
            end
            LANE1: begin
                if (!empty1) begin
                    pop1     = 1'b1;
                    next_out = {1'b1, dout1};
                    next_sel = LANE0;
                end
            end
            default: begin
                next_sel = LANE0;
            end
        endcase
    end

    // Lane selection state register.
    always_ff @(posedge clk2f) begin
        if (!reset_L) sel <= LANE0;
        else          sel <= next_sel;
    end

    // Registered output word and sticky error flags.
    always_ff @(posedge clk2f) begin
        if (!reset_L) begin
            dataout0     <= '0;
            overflow_err <= 1'b0;
            order_err    <= 1'b0;
        end else begin
            dataout0     <= next_out;
            overflow_err <= overflow_err | overflow_event;
            order_err    <= order_err | order_event;
        end
    end

endmodule

// File: tb/tb_byte_unstriping.sv
// Self-checking bench for byte_unstriping: directed scenarios plus random
// traffic, compared every cycle against a queue-based reference model.
module tb_byte_unstriping;
    import byte_unstriping_pkg::*;

    localparam int DEPTH = 4;

    logic              clk2f = 1'b0;
    logic              reset_L;
    logic              lane_strobe;
    logic [LANE_W-1:0] lane0;
    logic [LANE_W-1:0] lane1;
    logic [LANE_W-1:0] dataout0;
    logic              overflow_err;
    logic              order_err;

    int vectors     = 0;
    int miscompares = 0;

    // Reference model state: lane queues, turn flag, output and error flags.
    logic [LANE_W-1:0]     q0[$];
    logic [DEF_DATA_W-1:0] q1[$];
    logic                  m_sel;
    logic [LANE_W-1:0]     m_out;
    logic                  m_ovf;
    logic                  m_ord;

    byte_unstriping #(
        .DATA_W (DEF_DATA_W),
        .DEPTH  (DEPTH)
    ) dut (
        .clk2f        (clk2f),
        .reset_L      (reset_L),
        .lane_strobe  (lane_strobe),
        .lane0        (lane0),
        .lane1        (lane1),
        .dataout0     (dataout0),
        .overflow_err (overflow_err),
        .order_err    (order_err)
    );

    // Free-running byte-rate clock.
    always #5 clk2f = ~clk2f;

    function automatic logic [LANE_W-1:0] rand_word(input int valid_pct);
        logic [DEF_DATA_W-1:0] b;
        logic                  v;
        b = DEF_DATA_W'($urandom);
        v = ($urandom_range(0, 99) < valid_pct);
        return {v, b};
    endfunction

    // One clock edge of the reference: read first, then write into the queues.
    task automatic model_update();
        logic [LANE_W-1:0] w;
        if (!reset_L) begin
            q0.delete();
            q1.delete();
            m_sel = 1'b0;
            m_out = '0;
            m_ovf = 1'b0;
            m_ord = 1'b0;
        end else begin
            m_out = '0;
            if (!m_sel && q0.size() > 0) begin
                w     = q0.pop_front();
                m_out = {1'b1, w[DEF_DATA_W-1:0]};
                m_sel = w[VALID_BIT];
            end else if (m_sel && q1.size() > 0) begin
                m_out = {1'b1, q1.pop_front()};
                m_sel = 1'b0;
            end
            if (lane_strobe) begin
                if (lane0[VALID_BIT]) begin
                    if (q0.size() < DEPTH)
                        q0.push_back({lane1[VALID_BIT], lane0[DEF_DATA_W-1:0]});
                    else
                        m_ovf = 1'b1;
                end
                if (lane0[VALID_BIT] && lane1[VALID_BIT]) begin
                    if (q1.size() < DEPTH) q1.push_back(lane1[DEF_DATA_W-1:0]);
                    else                   m_ovf = 1'b1;
                end
                if (!lane0[VALID_BIT] && lane1[VALID_BIT]) m_ord = 1'b1;
            end
        end
    endtask

    // Drive one cycle of inputs, clock it, update the model, settle outputs.
    task automatic tick(input logic rst_n, input logic stb,
                        input logic [LANE_W-1:0] l0, input logic [LANE_W-1:0] l1);
        reset_L     = rst_n;
        lane_strobe = stb;
        lane0       = l0;
        lane1       = l1;
        @(posedge clk2f);
        model_update();
        #1;
    endtask

    task automatic test_reset();
        for (int i = 0; i < 3; i++) begin
            tick(1'b0, 1'b1, rand_word(50), rand_word(50));
            vectors++;
            if (dataout0 !== 9'h000 || overflow_err !== 1'b0 || order_err !== 1'b0) begin
                miscompares++;
                $display("[TB] FAIL reset_hold[%0d] got out=%h ovf=%b ord=%b want 000/0/0",
                         i, dataout0, overflow_err, order_err);
            end
        end
        for (int i = 0; i < 10; i++) begin
            tick(1'b1, 1'b0, rand_word(80), rand_word(80));
            vectors++;
            if (dataout0 !== 9'h000 || overflow_err !== 1'b0 || order_err !== 1'b0) begin
                miscompares++;
                $display("[TB] FAIL reset_idle[%0d] got out=%h ovf=%b ord=%b want 000/0/0",
                         i, dataout0, overflow_err, order_err);
            end
        end
    endtask

    task automatic test_back_to_back();
        logic              stb [6];
        logic [LANE_W-1:0] l0  [6];
        logic [LANE_W-1:0] l1  [6];
        logic [LANE_W-1:0] exp [6];
        stb = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
        l0  = '{9'h1AA, 9'h000, 9'h1CC, 9'h000, 9'h000, 9'h000};
        l1  = '{9'h1BB, 9'h000, 9'h1DD, 9'h000, 9'h000, 9'h000};
        exp = '{9'h000, 9'h1AA, 9'h1BB, 9'h1CC, 9'h1DD, 9'h000};
        tick(1'b0, 1'b0, '0, '0);
        for (int i = 0; i < 6; i++) begin
            tick(1'b1, stb[i], l0[i], l1[i]);
            vectors++;
            if (dataout0 !== exp[i] || dataout0 !== m_out) begin
                miscompares++;
                $display("[TB] FAIL back_to_back[%0d] got out=%h want %h (model %h)",
                         i, dataout0, exp[i], m_out);
            end
        end
    endtask

    task automatic test_odd_burst();
        logic              stb [8];
        logic [LANE_W-1:0] l0  [8];
        logic [LANE_W-1:0] l1  [8];
        logic [LANE_W-1:0] exp [8];
        stb = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
        l0  = '{9'h1A1, 9'h000, 9'h1C3, 9'h000, 9'h1D4, 9'h000, 9'h000, 9'h000};
        l1  = '{9'h1B2, 9'h000, 9'h000, 9'h000, 9'h1E5, 9'h000, 9'h000, 9'h000};
        exp = '{9'h000, 9'h1A1, 9'h1B2, 9'h1C3, 9'h000, 9'h1D4, 9'h1E5, 9'h000};
        tick(1'b0, 1'b0, '0, '0);
        for (int i = 0; i < 8; i++) begin
            tick(1'b1, stb[i], l0[i], l1[i]);
            vectors++;
            if (dataout0 !== exp[i] || dataout0 !== m_out) begin
                miscompares++;
                $display("[TB] FAIL odd_burst[%0d] got out=%h want %h (model %h)",
                         i, dataout0, exp[i], m_out);
            end
        end
    endtask

    task automatic test_order_err();
        logic              stb [8];
        logic [LANE_W-1:0] l0  [8];
        logic [LANE_W-1:0] l1  [8];
        logic [LANE_W-1:0] exp [8];
        stb = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
        l0  = '{9'h000, 9'h000, 9'h000, 9'h000, 9'h177, 9'h000, 9'h000, 9'h000};
        l1  = '{9'h155, 9'h000, 9'h000, 9'h000, 9'h188, 9'h000, 9'h000, 9'h000};
        exp = '{9'h000, 9'h000, 9'h000, 9'h000, 9'h000, 9'h177, 9'h188, 9'h000};
        tick(1'b0, 1'b0, '0, '0);
        for (int i = 0; i < 8; i++) begin
            tick(1'b1, stb[i], l0[i], l1[i]);
            vectors++;
            if (dataout0 !== exp[i] || order_err !== 1'b1 || overflow_err !== 1'b0) begin
                miscompares++;
                $display("[TB] FAIL order_err[%0d] got out=%h ord=%b ovf=%b want %h/1/0",
                         i, dataout0, order_err, overflow_err, exp[i]);
            end
        end
    endtask

    task automatic test_overflow();
        tick(1'b0, 1'b0, '0, '0);
        for (int i = 0; i < 32; i++) begin
            if (i < 12)
                tick(1'b1, 1'b1, {1'b1, 8'($urandom)}, {1'b1, 8'($urandom)});
            else
                tick(1'b1, 1'b0, '0, '0);
            vectors++;
            if (dataout0 !== m_out || overflow_err !== m_ovf || order_err !== m_ord) begin
                miscompares++;
                $display("[TB] FAIL overflow[%0d] got out=%h ovf=%b ord=%b want %h/%b/%b",
                         i, dataout0, overflow_err, order_err, m_out, m_ovf, m_ord);
            end
        end
        vectors++;
        if (overflow_err !== 1'b1 || order_err !== 1'b0) begin
            miscompares++;
            $display("[TB] FAIL overflow_sticky got ovf=%b ord=%b want 1/0",
                     overflow_err, order_err);
        end
    endtask

    task automatic test_reset_mid_burst();
        logic              rst [11];
        logic              stb [11];
        logic [LANE_W-1:0] l0  [11];
        logic [LANE_W-1:0] l1  [11];
        logic [LANE_W-1:0] exp [11];
        rst = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1};
        stb = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
        l0  = '{9'h111, 9'h000, 9'h133, 9'h1EE, 9'h000, 9'h000, 9'h000,
                9'h1F0, 9'h000, 9'h000, 9'h000};
        l1  = '{9'h122, 9'h000, 9'h144, 9'h1EF, 9'h000, 9'h000, 9'h000,
                9'h1F1, 9'h000, 9'h000, 9'h000};
        exp = '{9'h000, 9'h111, 9'h122, 9'h000, 9'h000, 9'h000, 9'h000,
                9'h000, 9'h1F0, 9'h1F1, 9'h000};
        tick(1'b0, 1'b0, '0, '0);
        for (int i = 0; i < 11; i++) begin
            tick(rst[i], stb[i], l0[i], l1[i]);
            vectors++;
            if (dataout0 !== exp[i] || dataout0 !== m_out ||
                overflow_err !== 1'b0 || order_err !== 1'b0) begin
                miscompares++;
                $display("[TB] FAIL reset_mid[%0d] got out=%h ovf=%b ord=%b want %h/0/0",
                         i, dataout0, overflow_err, order_err, exp[i]);
            end
        end
    endtask

    task automatic test_random();
        int   gap;
        logic rst_n;
        logic stb;
        gap = 0;
        tick(1'b0, 1'b0, '0, '0);
        for (int i = 0; i < 800; i++) begin
            rst_n = ($urandom_range(0, 249) != 0);
            stb   = 1'b0;
            if (gap == 0) stb = ($urandom_range(0, 3) != 0);
            tick(rst_n, stb, rand_word(85), rand_word(80));
            if (stb) gap = ($urandom_range(0, 9) == 0) ? 0 : 1;
            else if (gap > 0) gap--;
            vectors++;
            if (dataout0 !== m_out || overflow_err !== m_ovf || order_err !== m_ord) begin
                miscompares++;
                $display("[TB] FAIL random[%0d] got out=%h ovf=%b ord=%b want %h/%b/%b",
                         i, dataout0, overflow_err, order_err, m_out, m_ovf, m_ord);
            end
        end
    endtask

    // Scenario sequence followed by the summary line.
    initial begin
        reset_L     = 1'b0;
        lane_strobe = 1'b0;
        lane0       = '0;
        lane1       = '0;
        m_sel       = 1'b0;
        m_out       = '0;
        m_ovf       = 1'b0;
        m_ord       = 1'b0;
        test_reset();
        test_back_to_back();
        test_odd_burst();
        test_order_err();
        test_overflow();
        test_reset_mid_burst();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
